// File: rtl/fir_tdm_sequencer.sv
// fir_tdm_sequencer: time-multiplexed single-multiplier FIR with sample/output handshakes and writable coefficients
module fir_tdm_sequencer #(
  parameter int NUM_TAPS     = 16,
  parameter int DATA_WIDTH   = 12,
  parameter int COEFF_WIDTH  = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SHIFT_RIGHT  = 11
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [DATA_WIDTH-1:0]         in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [OUTPUT_WIDTH-1:0]       out_data,
  output logic                                 out_sat,
  input  logic                                 coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]          coef_addr,
  input  logic signed [COEFF_WIDTH-1:0]        coef_data
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] OMAX = (ACC_WIDTH'(1) <<< (OUTPUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] OMIN = -OMAX - 1;
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (SHIFT_RIGHT - 1);
  localparam logic signed [15:0] INIT [16] = '{
    -16'sd116, -16'sd226, -16'sd179, 16'sd184, 16'sd845, 16'sd1594, 16'sd2110, 16'sd2177,
    16'sd1710, 16'sd790, -16'sd261, -16'sd1153, -16'sd1638, -16'sd1589, -16'sd1014, -16'sd28};
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic signed [COEFF_WIDTH-1:0] coef [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  x    [NUM_TAPS];
  logic [AW-1:0] wr_ptr, rd_ptr, k, wr_next, rd_prev;
  logic signed [ACC_WIDTH-1:0] acc, acc_n, shifted;
  logic signed [PW-1:0] prod;
  logic signed [OUTPUT_WIDTH-1:0] sat_val;
  logic sat_n, last, accept;
  assign in_ready  = state == IDLE;
  assign out_valid = state == OUT;
  assign accept    = in_ready && in_valid;
  assign last      = k == AW'(NUM_TAPS - 1);
  assign wr_next   = wr_ptr == AW'(NUM_TAPS - 1) ? '0 : wr_ptr + 1'b1;
  assign rd_prev   = rd_ptr == '0 ? AW'(NUM_TAPS - 1) : rd_ptr - 1'b1;
  // rd_ptr walks backwards from the newest sample, so tap k always sees x[n-k]
  always_comb begin
    prod    = PW'(coef[k]) * PW'(x[rd_ptr]);
    acc_n   = acc + ACC_WIDTH'(prod);
    shifted = (acc_n + HALF) >>> SHIFT_RIGHT;
    sat_n   = shifted > OMAX || shifted < OMIN;
    sat_val = shifted > OMAX ? OMAX[OUTPUT_WIDTH-1:0] :
              shifted < OMIN ? OMIN[OUTPUT_WIDTH-1:0] : shifted[OUTPUT_WIDTH-1:0];
    state_n = state == IDLE ? (in_valid ? MAC : IDLE) :
              state == MAC  ? (last ? OUT : MAC) :
              state == OUT  ? (out_ready ? IDLE : OUT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x[i]    <= '0;
        coef[i] <= COEFF_WIDTH'(INIT[i % 16]);
      end
    end else begin
      state <= state_n;
      if (in_ready && coef_we) coef[coef_addr] <= coef_data;
      if (accept) begin
        x[wr_ptr] <= in_data;
        wr_ptr    <= wr_next;
        rd_ptr    <= wr_ptr;
        k         <= '0;
        acc       <= '0;
      end
      if (state == MAC) begin
        acc    <= acc_n;
        k      <= last ? '0 : k + 1'b1;
        rd_ptr <= rd_prev;
        if (last) begin
          out_data <= sat_val;
          out_sat  <= sat_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// tb_fir_tdm_sequencer: table-driven and scoreboard checks of the TDM FIR sequencer
module tb_fir_tdm_sequencer;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_sat, coef_we;
  logic [11:0] in_data;
  logic [15:0] out_data, coef_data;
  logic [3:0] coef_addr;
  typedef struct { int d; bit s; } exp_t;
  typedef struct { int x; int d; bit s; } vec_t;
  exp_t q[$];
  vec_t tbl[16];
  int n_chk = 0, n_fail = 0;
  int mcoef[16], hist[16];
  int opt_hold = 0;
  bit opt_macwe = 0, opt_accwe = 0;
  int opt_addr = 0, opt_cdata = 0;
  int dcoef[16] = '{-116, -226, -179, 184, 845, 1594, 2110, 2177, 1710, 790, -261, -1153, -1638, -1589, -1014, -28};
  int imp[16] = '{-58, -113, -89, 92, 423, 797, 1055, 1089, 855, 395, -130, -576, -819, -794, -507, -14};

  fir_tdm_sequencer dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input longint a, input longint e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic void model(output int d, output bit s);
    longint acc = 0;
    for (int i = 0; i < 16; i++) acc += longint'(mcoef[i]) * hist[i];
    acc = (acc + 1024) >>> 11;
    s = acc > 32767 || acc < -32768;
    d = acc > 32767 ? 32767 : acc < -32768 ? -32768 : int'(acc);
  endfunction

  task automatic do_reset;
    rst = 1; in_valid = 0; out_ready = 0; coef_we = 0;
    tick; tick;
    rst = 0;
    mcoef = dcoef;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    q.delete();
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we = 1; coef_addr = 4'(a); coef_data = 16'(d);
    tick;
    coef_we = 0;
    mcoef[a] = d;
  endtask

  task automatic do_sample(input int x, input int ed, input bit es, input bit use_model);
    exp_t e;
    int cnt = 0, busy_ready = 0;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_data = 12'(x);
    if (opt_accwe) begin
      coef_we = 1; coef_addr = 4'(opt_addr); coef_data = 16'(opt_cdata);
      mcoef[opt_addr] = opt_cdata;
    end
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    if (use_model) model(ed, es);
    e.d = ed; e.s = es;
    q.push_back(e);
    tick;
    in_valid = 0; coef_we = 0;
    while (!out_valid && cnt < 40) begin
      if (in_ready) busy_ready++;
      in_valid = 1'($urandom_range(0, 1)); in_data = 12'($urandom);
      if (opt_macwe) begin coef_we = 1; coef_addr = 0; coef_data = 16'd5000; end
      tick;
      cnt++;
    end
    in_valid = 0; coef_we = 0;
    chk("latency", cnt, 16);
    chk("busy_in_ready", busy_ready, 0);
    if (out_valid) begin
      e = q.pop_front();
      chk("out_data", $signed(out_data), e.d);
      chk("out_sat", out_sat, e.s);
      for (int h = 0; h < opt_hold; h++) begin
        in_valid = 1; in_data = 12'($urandom);
        tick;
        chk("hold_valid", out_valid, 1);
        chk("hold_data", $signed(out_data), e.d);
        chk("hold_sat", out_sat, e.s);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 0; out_ready = 1;
      tick;
      out_ready = 0;
      chk("post_valid", out_valid, 0);
      chk("post_ready", in_ready, 1);
    end
  endtask

  initial begin
    in_data = 0; coef_addr = 0; coef_data = 0;
    do_reset;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    // impulse response, with backpressure on one output
    for (int i = 0; i < 16; i++) tbl[i] = '{(i == 0) ? 1024 : 0, imp[i], 1'b0};
    for (int i = 0; i < 16; i++) begin
      opt_hold = (i == 3) ? 5 : 0;
      do_sample(tbl[i].x, tbl[i].d, tbl[i].s, 0);
    end
    opt_hold = 0;
    // random coefficients and samples against the reference model
    for (int i = 0; i < 4; i++) wcoef(int'($urandom_range(0, 15)), int'($urandom_range(0, 4000)) - 2000);
    for (int i = 0; i < 6; i++) do_sample(int'($urandom_range(0, 4095)) - 2048, 0, 0, 1);
    // coefficient write on the acceptance edge
    opt_accwe = 1; opt_addr = 0; opt_cdata = 8000;
    do_sample(1000, 0, 0, 1);
    opt_accwe = 0;
    // writes during MAC are ignored
    do_reset;
    opt_macwe = 1;
    do_sample(1024, -58, 0, 0);
    opt_macwe = 0;
    do_sample(1024, 0, 0, 1);
    // reset during MAC aborts the sample and clears the buffer
    do_reset;
    in_valid = 1; in_data = 12'd1024;
    tick;
    in_valid = 0;
    repeat (8) tick;
    rst = 1;
    tick;
    rst = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (out_valid) seen++;
        tick;
      end
      chk("abort_no_valid", seen, 0);
    end
    do_sample(1024, -58, 0, 0);
    // saturation in both directions
    do_reset;
    for (int i = 0; i < 16; i++) wcoef(i, 32767);
    for (int i = 0; i < 16; i++) do_sample(2047, 32767, 1, i != 15);
    for (int i = 0; i < 16; i++) wcoef(i, -32768);
    do_sample(2047, -32768, 1, 0);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
